// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and arbiter state encoding shared by the ALU arbiter slice
package alu_pkg;
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_e;
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_DONE  = 2'b11
   } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector; the last-grant pointer moves only on advance
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);
   logic last;
   always_comb begin
      grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
   end
   always_ff @(posedge clk) begin
      if (!rst_b) last <= 1'b1;
      else if (advance && |grant) last <= grant[1];
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters with round-robin
// arbitration, a bounded wait for alu_stop and single-cycle gnt/done/err pulses.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TIMEOUT = 320,
   parameter int W       = 64
) (
   input  logic           clk,
   input  logic           rst_b,
   input  logic           req0,
   input  logic           req1,
   input  logic [1:0]     opc0,
   input  logic [1:0]     opc1,
   input  logic [W-1:0]   x0,
   input  logic [W-1:0]   y0,
   input  logic [W-1:0]   x1,
   input  logic [W-1:0]   y1,
   output logic           gnt0,
   output logic           gnt1,
   output logic           done0,
   output logic           done1,
   output logic           err0,
   output logic           err1,
   output logic [2*W-1:0] res,
   output logic           busy,
   output logic           alu_bgn,
   output logic [1:0]     alu_opcode,
   output logic [W-1:0]   alu_x,
   output logic [W-1:0]   alu_y,
   input  logic           alu_stop,
   input  logic [2*W-1:0] alu_res
);
   localparam int CW = $clog2(TIMEOUT + 1);
   arb_state_e    state, state_nxt;
   logic [CW-1:0] cnt;
   logic          owner;
   logic [1:0]    grant;
   logic          take, timeout;
   rr_arb2 u_rr (
      .clk     (clk),
      .rst_b   (rst_b),
      .req     ({req1, req0}),
      .advance (take),
      .grant   (grant)
   );
   // gnt is decoded in IDLE so the next grant can land two cycles after alu_stop
   always_comb begin
      take      = (state == S_IDLE) && rst_b && (|grant);
      timeout   = (state == S_WAIT) && !alu_stop && (cnt == CW'(TIMEOUT - 1));
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = take ? S_ISSUE : S_IDLE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = alu_stop ? S_DONE : (timeout ? S_IDLE : S_WAIT);
         default: state_nxt = S_IDLE;
      endcase
      gnt0    = take && grant[0];
      gnt1    = take && grant[1];
      done0   = (state == S_DONE) && !owner;
      done1   = (state == S_DONE) && owner;
      err0    = timeout && !owner;
      err1    = timeout && owner;
      busy    = (state != S_IDLE);
      alu_bgn = (state == S_ISSUE);
   end
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state      <= S_IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         res        <= '0;
         alu_opcode <= '0;
         alu_x      <= '0;
         alu_y      <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            owner      <= grant[1];
            alu_opcode <= grant[1] ? opc1 : opc0;
            alu_x      <= grant[1] ? x1 : x0;
            alu_y      <= grant[1] ? y1 : y0;
            res        <= '0;
         end
         // saturating count: it never wraps even if the wait outlives TIMEOUT
         if (state == S_ISSUE) cnt <= '0;
         else if (state == S_WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
         if (state == S_WAIT && alu_stop) res <= alu_res;
         else if (timeout) res <= '0;
      end
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 320, the number of cycles to wait for alu_stop before aborting.
REQ-002 SHALL have parameter W, default 64, the operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_b, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: requester holds high until its done/err pulse.
REQ-006 SHALL have ports opc0/opc1, input, 2 bits each: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have ports x0,y0/x1,y1, input, W bits each: operands.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle grant pulse.
REQ-009 SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1, output, 1 bit each: one-cycle timeout pulse.
REQ-011 SHALL have port res, output, 2W bits: result, valid while done0 or done1 is high.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port alu_bgn, output, 1 bit: start pulse to the ALU.
REQ-014 SHALL have ports alu_opcode, output, 2 bits, and alu_x/alu_y, output, W bits each: registered operation and operands, held stable from ISSUE through WAIT.
REQ-015 SHALL have port alu_stop, input, 1 bit: ALU completion.
REQ-016 SHALL have port alu_res, input, 2W bits: ALU result, sampled when alu_stop is high.

Function
REQ-017 SHALL implement four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE SHALL behave as follows:
- If any req is high, grant one requester by the round-robin rule (REQ-023).
- Latch that requester's opc/x/y into alu_opcode/alu_x/alu_y.
- Pulse its gnt for one cycle and move to ISSUE.
- With no req, stay in IDLE.
REQ-019 ISSUE SHALL assert alu_bgn for exactly one cycle, clear the timeout counter, and move to WAIT.
REQ-020 WAIT SHALL behave as follows:
- On alu_stop: capture alu_res into res and move to DONE.
- Otherwise increment the counter.
- When the counter reaches TIMEOUT-1 without alu_stop: pulse err of the owner, set res to 0, and return to IDLE.
REQ-021 DONE SHALL pulse done of the owner for one cycle, hold res, and return to IDLE.
REQ-022 Latency SHALL be:
- gnt at cycle N, alu_bgn at N+1.
- alu_stop seen at cycle S gives done at S+1.
- The earliest next grant is at S+2.
REQ-023 Arbitration SHALL be round-robin between the two requesters:
- When both req are high in IDLE, grant the one not granted last.
- After reset, requester 0 has priority.
REQ-024 A req deasserted after its grant SHALL NOT abort the operation; completion is still signalled.
REQ-025 A req change on a non-owner SHALL be ignored until IDLE.
REQ-026 alu_stop asserted in IDLE, ISSUE or DONE SHALL be ignored.
REQ-027 alu_stop coinciding with the final timeout cycle SHALL count as completion (done, not err).
REQ-028 At most one of gnt0, gnt1, done0, done1, err0, err1 SHALL be high in any cycle.
REQ-029 The counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL NOT wrap.
REQ-030 alu_x and alu_y SHALL NOT change between the grant and leaving WAIT.

Reset
REQ-031 Reset SHALL be sampled only on the rising edge of clk while rst_b is low.
REQ-032 On reset, the following SHALL be set:
- State to IDLE, counter to 0, last-grant pointer to requester 1 (so requester 0 wins first).
- All pulses, alu_bgn and busy to 0.
- res, alu_opcode, alu_x and alu_y to 0.
REQ-033 Reset mid-operation SHALL abandon the operation silently, with no done or err pulse; the requester re-requests.

Structure
REQ-034 Opcode constants (ADD, SUB, MUL, DIV) and the arbiter state encoding SHALL live in shared package alu_pkg.
REQ-035 The two-way round-robin selection SHALL be a sub-module rr_arb2, with inputs req[1:0] and advance and output grant[1:0] one-hot; the pointer updates only on advance.
REQ-036 The ALU core SHALL be instantiated outside this block; alu_arbiter SHALL hold no arithmetic.

Verification
REQ-037 req0 alone, opc0=00, x0=5, y0=7, ALU model stops 4 cycles after bgn -> gnt0, bgn one cycle later, done0 with res=12, busy low after done.
REQ-038 req0 and req1 both high in the same cycle after reset, both mul, x0=3,y0=4 and x1=6,y1=7 -> gnt0 first with res=12, then gnt1 with res=42, never overlapping.
REQ-039 req1 held continuously while req0 requests repeatedly -> grants alternate 0,1,0,1.
REQ-040 ALU model never asserts stop, TIMEOUT=320 -> err pulse exactly 320 cycles after alu_bgn, res=0, IDLE next cycle.
REQ-041 stop in the final timeout cycle -> done, no err; spurious alu_stop in IDLE -> no pulse.
REQ-042 rst_b low during WAIT of a div -> next cycle IDLE, busy=0, no done or err, then a fresh req0 completes normally.
